// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB writes normally win, and auxiliary
// results wait in a 2-entry FIFO with a bounded wait enforced by a one-cycle stall.
`timescale 1ns/1ps

module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [ADDR_WIDTH-1:0] pipe_addr,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  pipe_stall,
    input  logic                  aux_valid,
    output logic                  aux_ready,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_next;

    logic [ADDR_WIDTH-1:0] fifo_addr [2];
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic fifo_empty;
    logic push;
    logic pop;
    logic grant_pipe;
    logic grant_aux;
    logic head_denied;

    // Handshake: an aux entry transfers on any rising edge where aux_valid and
    // aux_ready are both high; aux_ready depends only on the FIFO fill level.
    assign fifo_empty  = (count == 2'd0);
    assign aux_ready   = (count < 2'd2);
    assign push        = aux_valid && aux_ready;

    // In FORCE the FIFO always holds the starved head, so the aux grant is unconditional.
    assign grant_pipe  = (state == ST_NORMAL) && pipe_we;
    assign grant_aux   = !fifo_empty && ((state == ST_FORCE) || !pipe_we);
    assign pop         = grant_aux;
    assign head_denied = !fifo_empty && !grant_aux;

    always_comb begin
        wait_next  = '0;
        state_next = ST_NORMAL;
        if (head_denied) begin
            wait_next = (wait_cnt == WAIT_SAT) ? WAIT_SAT : wait_cnt + WAIT_W'(1);
            if ((state == ST_NORMAL) && (wait_cnt == WAIT_LAST)) begin
                state_next = ST_FORCE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_NORMAL;
            wait_cnt   <= '0;
            pipe_stall <= 1'b0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_next;
            pipe_stall <= (state_next == ST_FORCE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= aux_addr;
            fifo_data[wr_ptr] <= aux_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (grant_pipe) begin
            rf_we   <= 1'b1;
            rf_addr <= pipe_addr;
            rf_data <= pipe_data;
        end else if (grant_aux) begin
            rf_we   <= 1'b1;
            rf_addr <= fifo_addr[rd_ptr];
            rf_data <= fifo_data[rd_ptr];
        end else begin
            rf_we   <= 1'b0;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the MEM/WB pipeline stage and an auxiliary multi-cycle result source, such as a mul/div unit or a load refill. The block sits between the MEM/WB pipeline register outputs and the register file. Pipeline writebacks normally win. Auxiliary results are buffered in a 2-entry FIFO and are guaranteed a slot within MAX_WAIT cycles by forcing a one-cycle pipeline stall.

## Interface
Parameters:
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 3, register address width (8 registers)
- MAX_WAIT, 4, consecutive denied cycles before a forced aux grant (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_we  in  1  MEM/WB write request (wb_ctrl regwrite bit)
- pipe_addr  in  ADDR_WIDTH  MEM/WB destination register
- pipe_data  in  DATA_WIDTH  MEM/WB writeback data
- pipe_stall  out  1  registered; pipeline must hold MEM/WB contents this cycle
- aux_valid  in  1  aux result offered
- aux_ready  out  1  combinational, high when FIFO count < 2
- aux_addr  in  ADDR_WIDTH  aux destination register
- aux_data  in  DATA_WIDTH  aux result data
- rf_we  out  1  registered register-file write enable
- rf_addr  out  ADDR_WIDTH  registered write address
- rf_data  out  DATA_WIDTH  registered write data

## Operation
- Aux FIFO:
  - 2 entries, each holding {addr, data}.
  - Push when aux_valid && aux_ready. A push is only possible when count < 2, so there is no push-when-full.
  - Pop only when the head is granted.
  - Push and pop may occur in the same cycle. Count is unchanged and FIFO order is preserved.
- State machine, 2 states:
  - NORMAL: if pipe_we, grant the pipe. Otherwise, if the FIFO is non-empty, grant the aux head. Otherwise no grant.
  - FORCE: pipe_stall=1. Grant the aux head unconditionally; pipe_we is ignored because the pipeline re-presents the same write next cycle. Always return to NORMAL after one cycle.
- wait_cnt:
  - Increments at each edge where the FIFO was non-empty and the head was not granted. Saturates at MAX_WAIT.
  - Clears at any edge where the head is granted or the FIFO is empty.
- Transition NORMAL→FORCE: at the edge where wait_cnt increments to MAX_WAIT.
- Write ordering: same-address writes from the two sources retire in grant order. No other ordering is guaranteed.
- No special handling of register 0.

## Timing
- Reset (asynchronous, immediate): rf_we=0, rf_addr=0, rf_data=0, pipe_stall=0, state=NORMAL, wait_cnt=0, FIFO empty, so aux_ready=1.
  - Reset mid-operation discards buffered aux entries and aborts a pending FORCE.
- Grant→register-file latency is 1 cycle. The winner of cycle t appears on rf_* during cycle t+1. With no grant, rf_we=0 and rf_addr/rf_data hold their previous values.
- Aux acceptance→earliest grant is 1 cycle. An entry pushed at edge E can be granted in the cycle after E at the earliest.
- Worst-case aux head wait:
  - MAX_WAIT denied cycles, then the FORCE cycle.
  - The write appears on rf_* MAX_WAIT+2 cycles after the push edge.
- pipe_stall:
  - High for exactly one cycle per FORCE. Never high two consecutive cycles.
  - After a FORCE, wait_cnt restarts from 0 for the new head.
- Back-to-back FORCE is impossible within MAX_WAIT cycles.

## Test plan
- Reset: assert rst mid-run with the FIFO at 2 entries and state FORCE → immediately rf_we=0, pipe_stall=0, aux_ready=1. The first post-reset aux push is granted 1 cycle later with pipe_we=0.
- Pipe only: pipe_we=1, addr=5, data=0xDEADBEEF for 3 cycles → rf_we=1, addr 5, data 0xDEADBEEF on each following cycle. pipe_stall stays 0.
- Aux idle path: pipe_we=0, push aux addr=2, data=0x1234 → rf_we=1, addr 2, data 0x1234 two cycles after the push edge.
- Starvation (MAX_WAIT=4): pipe_we=1 every cycle, push one aux entry at edge E0 →
  - cycles 1–4 grant the pipe.
  - cycle 5 has pipe_stall=1 and grants the aux.
  - rf_* shows the aux write in cycle 6 and the held pipe write in cycle 7.
  - pipe_stall=0 from cycle 6 on.
- FIFO full: pipe_we=1 continuously, aux_valid=1 with 3 distinct entries → aux_ready drops after 2 pushes. The third entry is accepted only in the cycle after the first FORCE pops the head. All three retire in push order.
- Simultaneous push/pop at count=1 → count stays 1, aux_ready stays 1, and no entry is lost or duplicated (checked by scoreboard over 1000 random cycles).
